// File: rtl/dp_ram_rw_pkg.sv
// Shared helpers for the dual-port RAM: the address range check used by both ports.
package dp_ram_rw_pkg;

   // The reset value of the read data register.
   localparam logic RdDataResetBit = 1'b0;

   // Returns 1 when the zero-extended address selects a real word.
   // This only matters when the depth is not a power of two.
   function automatic logic addr_in_range(input logic [31:0] addr, input int unsigned depth);
      return addr < depth;
   endfunction

endpackage

// File: rtl/dp_ram_rw.sv
// Simple dual-port RAM with one synchronous write port and one registered read port on a
// single clock. The read is read-first on a same-address collision. rst clears only the read
// data register. The array contents survive reset.
module dp_ram_rw
   import dp_ram_rw_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned DATA_DEPTH = 256
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          rd_en,
   input  logic [$clog2(DATA_DEPTH)-1:0] rd_addr,
   output logic [DATA_WIDTH-1:0]         rd_data,
   input  logic                          wr_en,
   input  logic [$clog2(DATA_DEPTH)-1:0] wr_addr,
   input  logic [DATA_WIDTH-1:0]         wr_data
);

   localparam int unsigned AW = $clog2(DATA_DEPTH);

   logic [DATA_WIDTH-1:0] mem [0:DATA_DEPTH-1];
   logic [DATA_WIDTH-1:0] rd_data_d, rd_data_q;
   logic                  rd_in_range, wr_in_range;

   // Range checks. These are constant-true when DATA_DEPTH is a power of two.
   always_comb begin
      rd_in_range = addr_in_range(32'(rd_addr), DATA_DEPTH);
      wr_in_range = addr_in_range(32'(wr_addr), DATA_DEPTH);
   end

   // Write port. rst is sampled synchronously here so a write seen during reset is dropped.
   // The array itself is never reset, so it stays inferable as block RAM.
   always_ff @(posedge clk) begin
      if (!rst && wr_en && wr_in_range) begin
         mem[wr_addr] <= wr_data;
      end
   end

   // Next read data. The register holds its value when disabled.
   // An out-of-range read loads zero. The old array word is read, which gives read-first.
   always_comb begin
      rd_data_d = rd_data_q;
      if (rd_en) begin
         if (rd_in_range) begin
            rd_data_d = mem[rd_addr];
         end else begin
            rd_data_d = '0;
         end
      end
   end

   // Read data register, cleared asynchronously by rst.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_data_q <= {DATA_WIDTH{RdDataResetBit}};
      end else begin
         rd_data_q <= rd_data_d;
      end
   end

   assign rd_data = rd_data_q;

   // AW is kept so that the address width is named in one place for readers.
   logic unused_aw;
   assign unused_aw = ^AW;

endmodule

// File: tb/tb_dp_ram_rw.sv
// Self-checking bench for dp_ram_rw. It uses a reference array and a read scoreboard queue.
module tb_dp_ram_rw;

   localparam int unsigned DW = 8;
   localparam int unsigned DEPTH = 256;
   localparam int unsigned AW = $clog2(DEPTH);

   logic          clk = 1'b0;
   logic          rst;
   logic          rd_en;
   logic [AW-1:0] rd_addr;
   logic [DW-1:0] rd_data;
   logic          wr_en;
   logic [AW-1:0] wr_addr;
   logic [DW-1:0] wr_data;

   logic [DW-1:0] model [0:DEPTH-1];
   logic [DW-1:0] exp_q [$];
   int            checks = 0;
   int            failures = 0;

   always #5 clk = ~clk;

   dp_ram_rw #(
      .DATA_WIDTH(DW),
      .DATA_DEPTH(DEPTH)
   ) dut (
      .clk    (clk),
      .rst    (rst),
      .rd_en  (rd_en),
      .rd_addr(rd_addr),
      .rd_data(rd_data),
      .wr_en  (wr_en),
      .wr_addr(wr_addr),
      .wr_data(wr_data)
   );

   // Single comparison point for every check in the bench.
   task automatic check_eq(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%02h expected 0x%02h", tag, got, exp);
      end
   endtask

   // One clock of stimulus. Inputs are driven 1ns after the edge and sampled 1ns after the next edge.
   // The expected read value is taken from the model before the write is applied (read-first).
   task automatic cycle(input logic re, input int ra, input logic we, input int wa,
                        input logic [DW-1:0] wd, input string tag);
      rd_en   = re;
      rd_addr = AW'(ra);
      wr_en   = we;
      wr_addr = AW'(wa);
      wr_data = wd;
      if (re) exp_q.push_back(model[ra]);
      if (we) model[wa] = wd;
      @(posedge clk);
      #1;
      if (re) begin
         if (exp_q.size() == 0) begin
            check_eq({tag, "_sb_empty"}, rd_data, 8'hxx);
         end else begin
            check_eq(tag, rd_data, exp_q.pop_front());
         end
      end
      rd_en = 1'b0;
      wr_en = 1'b0;
   endtask

   initial begin
      logic [DW-1:0] wr_bytes [0:3];
      logic [DW-1:0] held;
      wr_bytes[0] = 8'hDE;
      wr_bytes[1] = 8'hAD;
      wr_bytes[2] = 8'hBE;
      wr_bytes[3] = 8'hEF;

      rst = 1'b1;
      rd_en = 1'b0;
      wr_en = 1'b0;
      rd_addr = '0;
      wr_addr = '0;
      wr_data = '0;
      repeat (2) @(posedge clk);
      #1;
      check_eq("reset", rd_data, 8'h00);
      rst = 1'b0;

      // Write four bytes, then read them back one per cycle.
      for (int i = 0; i < 4; i++) cycle(1'b0, 0, 1'b1, i, wr_bytes[i], "wr");
      for (int i = 0; i < 4; i++) cycle(1'b1, i, 1'b0, 0, 8'h00, "wr_rd");

      // Full sweep with a checkerboard pattern.
      for (int i = 0; i < int'(DEPTH); i++)
         cycle(1'b0, 0, 1'b1, i, (i % 2 == 0) ? 8'h5A : 8'hA5, "wr");
      for (int i = 0; i < int'(DEPTH); i++) cycle(1'b1, i, 1'b0, 0, 8'h00, "sweep_pat");

      // Full sweep with random bytes. The reads overlap writes to other addresses.
      for (int i = 0; i < int'(DEPTH); i++)
         cycle(1'b0, 0, 1'b1, i, DW'($urandom_range(0, 255)), "wr");
      for (int i = 0; i < int'(DEPTH); i++)
         cycle(1'b1, i, 1'b1, (i + 128) % DEPTH, DW'($urandom_range(0, 255)), "sweep_rand");

      // Read hold: rd_data must keep mem[0] while rd_addr moves with rd_en low.
      cycle(1'b1, 0, 1'b0, 0, 8'h00, "hold_load");
      held = model[0];
      for (int i = 0; i < int'(DEPTH); i++) begin
         rd_en = 1'b0;
         rd_addr = AW'(i);
         @(posedge clk);
         #1;
         check_eq("read_hold", rd_data, held);
      end

      // Same-address collision: the read must return the old value.
      cycle(1'b0, 0, 1'b1, 5, 8'h11, "wr");
      cycle(1'b1, 5, 1'b1, 5, 8'h22, "collision_old");
      cycle(1'b1, 5, 1'b0, 0, 8'h00, "collision_new");

      // Mid-run reset: the clear is asynchronous, and accesses during reset are ignored.
      cycle(1'b0, 0, 1'b1, 7, 8'h3C, "wr");
      cycle(1'b1, 7, 1'b0, 0, 8'h00, "pre_reset_rd");
      #2;
      rst = 1'b1;
      #1;
      check_eq("async_reset", rd_data, 8'h00);
      rd_en = 1'b1;
      rd_addr = AW'(7);
      wr_en = 1'b1;
      wr_addr = AW'(7);
      wr_data = 8'hFF;
      @(posedge clk);
      #1;
      check_eq("reset_hold", rd_data, 8'h00);
      rd_en = 1'b0;
      wr_en = 1'b0;
      #2;
      rst = 1'b0;
      @(posedge clk);
      #1;
      cycle(1'b1, 7, 1'b0, 0, 8'h00, "post_reset_rd");

      check_eq("sb_drained", 8'(exp_q.size()), 8'h00);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
